// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA raster generator.
//   - vga_timing_t      : one complete video-mode timing set
//   - VGA_1280x1024_60  : 108 MHz SXGA timing (default)
//   - VGA_640x480_60    : 25.175 MHz VGA timing
//   - pat_mode_e        : run-time test-pattern select
//   - BAR_* / bar_rgb3  : colour-bar palette as one bit per channel; the
//                         user replicates each bit CW times ("white" = all ones)
package vga_pkg;

  typedef struct packed {
    int unsigned h_disp;
    int unsigned h_front;
    int unsigned h_sync;
    int unsigned h_back;
    int unsigned v_disp;
    int unsigned v_front;
    int unsigned v_sync;
    int unsigned v_back;
    logic        hs_pol;
    logic        vs_pol;
  } vga_timing_t;

  localparam vga_timing_t VGA_1280x1024_60 = '{
    h_disp: 32'd1280, h_front: 32'd48, h_sync: 32'd112, h_back: 32'd248,
    v_disp: 32'd1024, v_front: 32'd1,  v_sync: 32'd3,   v_back: 32'd38,
    hs_pol: 1'b1,     vs_pol: 1'b1
  };

  localparam vga_timing_t VGA_640x480_60 = '{
    h_disp: 32'd640, h_front: 32'd16, h_sync: 32'd96, h_back: 32'd48,
    v_disp: 32'd480, v_front: 32'd10, v_sync: 32'd2,  v_back: 32'd33,
    hs_pol: 1'b0,    vs_pol: 1'b0
  };

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRID  = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_SOLID = 2'd3
  } pat_mode_e;

  // {R,G,B} one bit per channel, scaled to CW bits by replication.
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  function automatic logic [2:0] bar_rgb3(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_core.sv
// vga_timing_core: raster counters plus registered sync / de / coordinates.
// Ports:
//   clk_vga, RST_N      pixel clock, async active-low reset
//   hcnt, vcnt          live counter values (for pattern logic upstream)
//   active              combinational active-video flag for hcnt/vcnt
//   hsync, vsync        registered sync outputs at the HS_POL/VS_POL level
//   de, pix_x, pix_y    registered data-enable and coordinates (0 in blanking)
//   frame_start         registered one-cycle pulse at pixel (0,0)
// All registered outputs lag hcnt/vcnt by exactly one cycle.
module vga_timing_core
  import vga_pkg::*;
#(
  parameter int H_DISP  = int'(VGA_1280x1024_60.h_disp),
  parameter int H_FRONT = int'(VGA_1280x1024_60.h_front),
  parameter int H_SYNC  = int'(VGA_1280x1024_60.h_sync),
  parameter int H_BACK  = int'(VGA_1280x1024_60.h_back),
  parameter int V_DISP  = int'(VGA_1280x1024_60.v_disp),
  parameter int V_FRONT = int'(VGA_1280x1024_60.v_front),
  parameter int V_SYNC  = int'(VGA_1280x1024_60.v_sync),
  parameter int V_BACK  = int'(VGA_1280x1024_60.v_back),
  parameter bit HS_POL  = 1'b1,
  parameter bit VS_POL  = 1'b1,
  parameter int XW      = $clog2(H_DISP + H_FRONT + H_SYNC + H_BACK),
  parameter int YW      = $clog2(V_DISP + V_FRONT + V_SYNC + V_BACK)
) (
  input  logic          clk_vga,
  input  logic          RST_N,
  output logic [XW-1:0] hcnt,
  output logic [YW-1:0] vcnt,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          frame_start
);

  localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;

  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT    = XW'(H_DISP);
  localparam logic [YW-1:0] V_ACT    = YW'(V_DISP);
  localparam logic [XW-1:0] HS_FIRST = XW'(H_DISP + H_FRONT);
  localparam logic [XW-1:0] HS_LAST  = XW'(H_DISP + H_FRONT + H_SYNC - 1);
  localparam logic [YW-1:0] VS_FIRST = YW'(V_DISP + V_FRONT);
  localparam logic [YW-1:0] VS_LAST  = YW'(V_DISP + V_FRONT + V_SYNC - 1);

  logic [XW-1:0] hcnt_r;
  logic [YW-1:0] vcnt_r;
  logic          active_s;
  logic          hs_act_s;
  logic          vs_act_s;
  logic          first_s;

  // Raster position counters; vcnt advances on the last pixel of each line.
  always_ff @(posedge clk_vga or negedge RST_N) begin
    if (!RST_N) begin
      hcnt_r <= {XW{1'b0}};
      vcnt_r <= {YW{1'b0}};
    end else if (hcnt_r == H_LAST) begin
      hcnt_r <= {XW{1'b0}};
      vcnt_r <= (vcnt_r == V_LAST) ? {YW{1'b0}} : vcnt_r + {{(YW-1){1'b0}}, 1'b1};
    end else begin
      hcnt_r <= hcnt_r + {{(XW-1){1'b0}}, 1'b1};
    end
  end

  // Window decode for the current counter values.
  always_comb begin
    active_s = (hcnt_r < H_ACT) && (vcnt_r < V_ACT);
    hs_act_s = (hcnt_r >= HS_FIRST) && (hcnt_r <= HS_LAST);
    vs_act_s = (vcnt_r >= VS_FIRST) && (vcnt_r <= VS_LAST);
    first_s  = (hcnt_r == {XW{1'b0}}) && (vcnt_r == {YW{1'b0}});
  end

  // Registered timing outputs, one cycle behind the counters.
  always_ff @(posedge clk_vga or negedge RST_N) begin
    if (!RST_N) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      pix_x       <= {XW{1'b0}};
      pix_y       <= {YW{1'b0}};
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_act_s ? HS_POL : ~HS_POL;
      vsync       <= vs_act_s ? VS_POL : ~VS_POL;
      de          <= active_s;
      pix_x       <= active_s ? hcnt_r : {XW{1'b0}};
      pix_y       <= active_s ? vcnt_r : {YW{1'b0}};
      frame_start <= first_s;
    end
  end

  assign hcnt   = hcnt_r;
  assign vcnt   = vcnt_r;
  assign active = active_s;

endmodule

// File: rtl/vga_timing_pattern_gen.sv
// vga_timing_pattern_gen: VGA raster generator with run-time test patterns.
// Ports:
//   clk_vga, RST_N                  pixel clock, async active-low reset
//   mode[1:0]                       0 bars, 1 grid, 2 gradient, 3 solid;
//                                   taken at the start of each frame
//   solid_rgb[3*CW-1:0]             {R,G,B} for solid mode, sampled per pixel
//   VGA_HSYNC, VGA_VSYNC            sync outputs
//   VGA_RED/GREEN/BLUE[CW-1:0]      pixel colour, 0 outside active video
//   de, pix_x, pix_y, frame_start   active flag, coordinates, frame pulse
// Every output is registered and aligned to the same counter values.
module vga_timing_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_DISP   = int'(VGA_1280x1024_60.h_disp),
  parameter int H_FRONT  = int'(VGA_1280x1024_60.h_front),
  parameter int H_SYNC   = int'(VGA_1280x1024_60.h_sync),
  parameter int H_BACK   = int'(VGA_1280x1024_60.h_back),
  parameter int V_DISP   = int'(VGA_1280x1024_60.v_disp),
  parameter int V_FRONT  = int'(VGA_1280x1024_60.v_front),
  parameter int V_SYNC   = int'(VGA_1280x1024_60.v_sync),
  parameter int V_BACK   = int'(VGA_1280x1024_60.v_back),
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CW       = 4,
  parameter int GRID     = 64,
  parameter int GR_SHIFT = 4,
  parameter int XW       = $clog2(H_DISP + H_FRONT + H_SYNC + H_BACK),
  parameter int YW       = $clog2(V_DISP + V_FRONT + V_SYNC + V_BACK)
) (
  input  logic            clk_vga,
  input  logic            RST_N,
  input  logic [1:0]      mode,
  input  logic [3*CW-1:0] solid_rgb,
  output logic            VGA_HSYNC,
  output logic            VGA_VSYNC,
  output logic [CW-1:0]   VGA_RED,
  output logic [CW-1:0]   VGA_GREEN,
  output logic [CW-1:0]   VGA_BLUE,
  output logic            de,
  output logic [XW-1:0]   pix_x,
  output logic [YW-1:0]   pix_y,
  output logic            frame_start
);

  localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
  localparam int BAR_W   = H_DISP / 8;
  localparam int BPW     = $clog2(BAR_W + 1);

  localparam logic [XW-1:0]  H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [BPW-1:0] BAR_LAST = BPW'(BAR_W - 1);
  localparam logic [XW-1:0]  X_EDGE   = XW'(H_DISP - 1);
  localparam logic [YW-1:0]  Y_EDGE   = YW'(V_DISP - 1);
  localparam logic [XW-1:0]  GMASK_X  = XW'(GRID - 1);
  localparam logic [YW-1:0]  GMASK_Y  = YW'(GRID - 1);

  logic [XW-1:0]   hcnt_s;
  logic [YW-1:0]   vcnt_s;
  logic            active_s;
  logic            first_s;
  pat_mode_e       mode_r;
  pat_mode_e       eff_mode_s;
  logic [BPW-1:0]  bar_px_r;
  logic [2:0]      bar_idx_r;
  logic            on_grid_s;
  logic [CW-1:0]   grad_s;
  logic [3*CW-1:0] rgb_s;
  logic [3*CW-1:0] rgb_r;

  function automatic logic [3*CW-1:0] expand3(input logic [2:0] c);
    return {{CW{c[2]}}, {CW{c[1]}}, {CW{c[0]}}};
  endfunction

  vga_timing_core #(
    .H_DISP (H_DISP),  .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_DISP (V_DISP),  .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .HS_POL (HS_POL),  .VS_POL (VS_POL),  .XW    (XW),     .YW    (YW)
  ) u_core (
    .clk_vga    (clk_vga),
    .RST_N      (RST_N),
    .hcnt       (hcnt_s),
    .vcnt       (vcnt_s),
    .active     (active_s),
    .hsync      (VGA_HSYNC),
    .vsync      (VGA_VSYNC),
    .de         (de),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_start(frame_start)
  );

  // The first pixel of a frame already uses the incoming mode, so the mode
  // register and the frame it governs switch on the same cycle.
  always_comb begin
    first_s = (hcnt_s == {XW{1'b0}}) && (vcnt_s == {YW{1'b0}});
    if (first_s) begin
      eff_mode_s = pat_mode_e'(mode);
    end else begin
      eff_mode_s = mode_r;
    end
  end

  // Frame-synchronous mode latch.
  always_ff @(posedge clk_vga or negedge RST_N) begin
    if (!RST_N) begin
      mode_r <= PAT_BARS;
    end else if (first_s) begin
      mode_r <= pat_mode_e'(mode);
    end
  end

  // Bar position without a divider: count pixels within a bar and step the
  // bar index each BAR_W pixels; both read 0 whenever hcnt is 0.
  always_ff @(posedge clk_vga or negedge RST_N) begin
    if (!RST_N) begin
      bar_px_r  <= {BPW{1'b0}};
      bar_idx_r <= 3'd0;
    end else if (hcnt_s == H_LAST) begin
      bar_px_r  <= {BPW{1'b0}};
      bar_idx_r <= 3'd0;
    end else if (bar_px_r == BAR_LAST) begin
      bar_px_r  <= {BPW{1'b0}};
      bar_idx_r <= bar_idx_r + 3'd1;
    end else begin
      bar_px_r  <= bar_px_r + {{(BPW-1){1'b0}}, 1'b1};
    end
  end

  // Pattern selection for the current counter position.
  always_comb begin
    on_grid_s = ((hcnt_s & GMASK_X) == {XW{1'b0}}) ||
                ((vcnt_s & GMASK_Y) == {YW{1'b0}}) ||
                (hcnt_s == X_EDGE) || (vcnt_s == Y_EDGE);
    grad_s    = CW'(hcnt_s >> GR_SHIFT);
    rgb_s     = {(3*CW){1'b0}};
    case (eff_mode_s)
      PAT_BARS:  rgb_s = expand3(bar_rgb3(bar_idx_r));
      PAT_GRID:  rgb_s = on_grid_s ? {(3*CW){1'b1}} : {(3*CW){1'b0}};
      PAT_GRAD:  rgb_s = {grad_s, grad_s, grad_s};
      PAT_SOLID: rgb_s = solid_rgb;
      default:   rgb_s = {(3*CW){1'b0}};
    endcase
  end

  // Colour output register, blanked outside active video.
  always_ff @(posedge clk_vga or negedge RST_N) begin
    if (!RST_N) begin
      rgb_r <= {(3*CW){1'b0}};
    end else begin
      rgb_r <= active_s ? rgb_s : {(3*CW){1'b0}};
    end
  end

  assign VGA_RED   = rgb_r[3*CW-1:2*CW];
  assign VGA_GREEN = rgb_r[2*CW-1:CW];
  assign VGA_BLUE  = rgb_r[CW-1:0];

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Self-checking bench for vga_timing_pattern_gen on a small video mode.
// Expected outputs come from the raster position (cycle index since reset
// release) using plain division/modulo, with the frame's pattern taken from
// the mode input present on the frame's first pixel.
module tb_vga_timing_pattern_gen;

  localparam int HD = 64, HF = 4, HS = 8, HB = 12;
  localparam int VD = 24, VF = 2, VS = 3, VB = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int CW = 4;
  localparam int GRID = 16;
  localparam int GRS = 2;
  localparam bit HSP = 1'b0;
  localparam bit VSP = 1'b1;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);

  logic            clk_vga = 1'b0;
  logic            RST_N = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic [3*CW-1:0] solid_rgb = 12'h000;
  logic            VGA_HSYNC, VGA_VSYNC, de, frame_start;
  logic [CW-1:0]   VGA_RED, VGA_GREEN, VGA_BLUE;
  logic [XW-1:0]   pix_x;
  logic [YW-1:0]   pix_y;

  int n_checks = 0;
  int n_pass   = 0;
  int frame_no = 0;
  int frame_mode = 0;
  int plan [4] = '{3, 0, 1, 2};
  int bars [8] = '{7, 6, 3, 2, 5, 4, 1, 0};

  always #5 clk_vga = ~clk_vga;

  vga_timing_pattern_gen #(
    .H_DISP(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISP(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HS_POL(HSP), .VS_POL(VSP), .CW(CW), .GRID(GRID), .GR_SHIFT(GRS)
  ) dut (
    .clk_vga    (clk_vga),
    .RST_N      (RST_N),
    .mode       (mode),
    .solid_rgb  (solid_rgb),
    .VGA_HSYNC  (VGA_HSYNC),
    .VGA_VSYNC  (VGA_VSYNC),
    .VGA_RED    (VGA_RED),
    .VGA_GREEN  (VGA_GREEN),
    .VGA_BLUE   (VGA_BLUE),
    .de         (de),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_start(frame_start)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, " hsync"}, 32'(VGA_HSYNC), 32'(!HSP));
    check_eq({tag, " vsync"}, 32'(VGA_VSYNC), 32'(!VSP));
    check_eq({tag, " de"}, 32'(de), 32'd0);
    check_eq({tag, " frame_start"}, 32'(frame_start), 32'd0);
    check_eq({tag, " rgb"}, 32'({VGA_RED, VGA_GREEN, VGA_BLUE}), 32'd0);
    check_eq({tag, " pix_x"}, 32'(pix_x), 32'd0);
    check_eq({tag, " pix_y"}, 32'(pix_y), 32'd0);
  endtask

  // Expected outputs for raster position pos under pattern fm.
  task automatic check_pixel(input int pos, input int fm, input int solid);
    int x, y, rgb, c3, g;
    bit act, hs_on, vs_on;
    x = pos % HT;
    y = pos / HT;
    act   = (x < HD) && (y < VD);
    hs_on = (x >= HD + HF) && (x < HD + HF + HS);
    vs_on = (y >= VD + VF) && (y < VD + VF + VS);
    rgb = 0;
    case (fm)
      0: begin
        c3 = bars[x / (HD / 8) % 8];
        if ((c3 & 4) != 0) rgb |= 'hF00;
        if ((c3 & 2) != 0) rgb |= 'h0F0;
        if ((c3 & 1) != 0) rgb |= 'h00F;
      end
      1: rgb = ((x % GRID == 0) || (y % GRID == 0) || (x == HD - 1) || (y == VD - 1)) ? 'hFFF : 0;
      2: begin
        g = (x >> GRS) % 16;
        rgb = g * 'h111;
      end
      default: rgb = solid;
    endcase
    if (!act) rgb = 0;
    check_eq("hsync", 32'(VGA_HSYNC), 32'(hs_on ? HSP : !HSP));
    check_eq("vsync", 32'(VGA_VSYNC), 32'(vs_on ? VSP : !VSP));
    check_eq("de", 32'(de), 32'(act));
    check_eq("pix_x", 32'(pix_x), act ? 32'(x) : 32'd0);
    check_eq("pix_y", 32'(pix_y), act ? 32'(y) : 32'd0);
    check_eq("frame_start", 32'(frame_start), 32'(pos == 0));
    check_eq("rgb", 32'({VGA_RED, VGA_GREEN, VGA_BLUE}), 32'(rgb));
  endtask

  // Runs ncyc clock edges from raster position 0; inputs change right after
  // each check so the values seen at the next edge are known to the model.
  task automatic run_cycles(input int ncyc);
    int pos;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk_vga);
      #1;
      pos = k % FT;
      if (pos == 0) frame_mode = int'(mode);
      check_pixel(pos, frame_mode, int'(solid_rgb));
      if ((k + 1) % FT == 0) begin
        mode = 2'(plan[frame_no % 4]);
        frame_no++;
      end else begin
        mode = 2'($urandom_range(0, 3));
      end
      solid_rgb = 12'($urandom);
    end
  endtask

  initial begin
    RST_N = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_vga);
      #1;
      check_reset("in_reset");
    end
    mode = 2'(plan[0]);
    frame_no = 1;
    RST_N = 1'b1;
    run_cycles(5 * FT);

    // Asynchronous reset in the middle of a line.
    run_cycles(HT * 5 + 17);
    @(posedge clk_vga);
    #3;
    RST_N = 1'b0;
    #1;
    check_reset("async_reset");
    repeat (3) @(posedge clk_vga);
    #1;
    check_reset("held_reset");
    mode = 2'(plan[frame_no % 4]);
    frame_no++;
    RST_N = 1'b1;
    run_cycles(FT + 100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
